// File: rtl/dp_controller.sv
// Instruction-sequencing FSM for the 16-bit RISC datapath: decodes a latched instruction and
// sequences the datapath strobes and the LDR/STR memory handshake. Optional: DP_CTRL_ILLEGAL_TRAP_EN.
module dp_controller #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    input  logic        mem_ready,
    output logic        w,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        load_addr,
    output logic [1:0]  mem_cmd,
    output logic        err
);

    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WB_REG, S_WB_IMM,
        S_ADDR, S_LATCH, S_MEM_RD, S_ST_B, S_ST_C, S_MEM_WR, S_HALT
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_hit;

    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    // The cycle that would make the count reach the limit is the last one a mem op may take.
    assign tmo_hit = (MEM_TIMEOUT != 0) && ({16'd0, tmo_q} + 32'd1 >= MEM_TIMEOUT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        tmo_d     = '0;
        w         = 1'b0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        ALUop     = 2'b00;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = 2'b00;
        err       = 1'b0;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == 3'b111) begin
                    state_d = S_HALT;
                end else begin
                    case ({opc, op})
                        5'b110_10:                       state_d = S_WB_IMM;
                        5'b110_00, 5'b101_11:            state_d = S_GET_B;
                        5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
                        5'b011_00, 5'b100_00:            state_d = S_GET_A;
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
                        default:                         state_d = S_TRAP;
`else
                        default:                         state_d = S_WAIT;
`endif
                    endcase
                end
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = (opc == 3'b011 || opc == 3'b100) ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                if (opc == 3'b101) begin
                    ALUop = op;
                end else begin
                    asel = 1'b1;
                end
                // CMP only updates the status register and writes nothing back.
                if (opc == 3'b101 && op == 2'b01) begin
                    loads   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WB_REG;
                end
            end
            S_WB_REG: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_WB_IMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_ADDR: begin
                bsel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                load_addr = 1'b1;
                state_d   = (opc == 3'b011) ? S_MEM_RD : S_ST_B;
            end
            S_MEM_RD: begin
                mem_cmd  = 2'b01;
                writenum = rd;
                vsel     = 2'b11;
                write    = mem_ready;
                tmo_d    = tmo_q + 16'd1;
                if (mem_ready || tmo_hit) state_d = S_WAIT;
            end
            S_ST_B: begin
                readnum = rd;
                loadb   = 1'b1;
                state_d = S_ST_C;
            end
            S_ST_C: begin
                asel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd = 2'b10;
                tmo_d   = tmo_q + 16'd1;
                if (mem_ready || tmo_hit) state_d = S_WAIT;
            end
            S_HALT: state_d = S_HALT;
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: err = 1'b1;
`endif
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_dp_controller.sv
// Self-checking bench for dp_controller: table of instructions with expected strobe activity,
// plus hand sequences for HALT, reset during a store handshake and the illegal-opcode trap.
module tb_dp_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_m, s_t, mem_ready;
    logic [15:0] in_r;
    bit          tsel;

    always #5 clk = ~clk;

    logic        m_w, m_loada, m_loadb, m_loadc, m_loads, m_asel, m_bsel, m_write, m_load_addr, m_err;
    logic [1:0]  m_vsel, m_shift, m_alu, m_mem_cmd;
    logic [2:0]  m_readnum, m_writenum;
    logic [15:0] m_sximm5, m_sximm8;
    logic        t_w, t_loada, t_loadb, t_loadc, t_loads, t_asel, t_bsel, t_write, t_load_addr, t_err;
    logic [1:0]  t_vsel, t_shift, t_alu, t_mem_cmd;
    logic [2:0]  t_readnum, t_writenum;
    logic [15:0] t_sximm5, t_sximm8;

    dp_controller dut (
        .clk(clk), .reset(reset), .s(s_m), .in(in_r), .mem_ready(mem_ready),
        .w(m_w), .vsel(m_vsel), .loada(m_loada), .loadb(m_loadb), .loadc(m_loadc),
        .loads(m_loads), .asel(m_asel), .bsel(m_bsel), .shift(m_shift), .ALUop(m_alu),
        .readnum(m_readnum), .writenum(m_writenum), .write(m_write), .sximm5(m_sximm5),
        .sximm8(m_sximm8), .load_addr(m_load_addr), .mem_cmd(m_mem_cmd), .err(m_err)
    );

    dp_controller #(.MEM_TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .s(s_t), .in(in_r), .mem_ready(mem_ready),
        .w(t_w), .vsel(t_vsel), .loada(t_loada), .loadb(t_loadb), .loadc(t_loadc),
        .loads(t_loads), .asel(t_asel), .bsel(t_bsel), .shift(t_shift), .ALUop(t_alu),
        .readnum(t_readnum), .writenum(t_writenum), .write(t_write), .sximm5(t_sximm5),
        .sximm8(t_sximm8), .load_addr(t_load_addr), .mem_cmd(t_mem_cmd), .err(t_err)
    );

    wire        o_w         = tsel ? t_w         : m_w;
    wire        o_loada     = tsel ? t_loada     : m_loada;
    wire        o_loadb     = tsel ? t_loadb     : m_loadb;
    wire        o_loadc     = tsel ? t_loadc     : m_loadc;
    wire        o_loads     = tsel ? t_loads     : m_loads;
    wire        o_asel      = tsel ? t_asel      : m_asel;
    wire        o_bsel      = tsel ? t_bsel      : m_bsel;
    wire        o_write     = tsel ? t_write     : m_write;
    wire        o_load_addr = tsel ? t_load_addr : m_load_addr;
    wire        o_err       = tsel ? t_err       : m_err;
    wire [1:0]  o_vsel      = tsel ? t_vsel      : m_vsel;
    wire [1:0]  o_shift     = tsel ? t_shift     : m_shift;
    wire [1:0]  o_alu       = tsel ? t_alu       : m_alu;
    wire [1:0]  o_mem_cmd   = tsel ? t_mem_cmd   : m_mem_cmd;
    wire [2:0]  o_readnum   = tsel ? t_readnum   : m_readnum;
    wire [2:0]  o_writenum  = tsel ? t_writenum  : m_writenum;
    wire [15:0] o_sximm5    = tsel ? t_sximm5    : m_sximm5;
    wire [15:0] o_sximm8    = tsel ? t_sximm8    : m_sximm8;

    wire m_any = |{m_vsel, m_loada, m_loadb, m_loadc, m_loads, m_asel, m_bsel, m_shift, m_alu,
                   m_readnum, m_writenum, m_write, m_load_addr, m_mem_cmd};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // delay: handshake cycles without mem_ready before it is given (99 = never).
    // lat: cycles with w=0 after capture. *_c fields: values seen on the last loadc/loads cycle.
    typedef struct {
        int tsel, instr, delay, lat;
        int n_loada, n_loadb, n_loadc, n_loads, n_write, n_ldaddr, n_memrd, n_memwr;
        int rn_a, rn_b, wnum, vsel_w;
        int alu_c, shift_c, asel_c, bsel_c;
        int x5, x8, n_err;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        vec_t o;
        int   held;
        bit   done;
        o    = '{default: 0};
        held = 0;
        done = 1'b0;
        tsel = (v.tsel != 0);
        @(negedge clk);
        in_r = v.instr[15:0];
        if (tsel) s_t = 1'b1; else s_m = 1'b1;
        @(posedge clk);
        #1;
        s_m = 1'b0;
        s_t = 1'b0;
        while (!done && o.lat < 40) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (o_mem_cmd != 2'b00) begin
                held++;
                if (held > v.delay) mem_ready = 1'b1;
            end
            #1;
            if (o_w) begin
                done = 1'b1;
            end else begin
                o.lat++;
                if (o_loada) begin o.n_loada++; o.rn_a = int'(o_readnum); end
                if (o_loadb) begin o.n_loadb++; o.rn_b = int'(o_readnum); end
                if (o_loadc || o_loads) begin
                    o.n_loadc += int'(o_loadc);
                    o.n_loads += int'(o_loads);
                    o.alu_c   = int'(o_alu);
                    o.shift_c = int'(o_shift);
                    o.asel_c  = int'(o_asel);
                    o.bsel_c  = int'(o_bsel);
                end
                if (o_write) begin o.n_write++; o.wnum = int'(o_writenum); o.vsel_w = int'(o_vsel); end
                if (o_load_addr) o.n_ldaddr++;
                if (o_mem_cmd == 2'b01) o.n_memrd++;
                if (o_mem_cmd == 2'b10) o.n_memwr++;
                if (o_err) o.n_err++;
            end
        end
        mem_ready = 1'b0;
        check($sformatf("v%0d w_returned", idx), 32'(done), 32'd1);
        check($sformatf("v%0d latency", idx),   o.lat,     v.lat);
        check($sformatf("v%0d n_loada", idx),   o.n_loada, v.n_loada);
        check($sformatf("v%0d n_loadb", idx),   o.n_loadb, v.n_loadb);
        check($sformatf("v%0d n_loadc", idx),   o.n_loadc, v.n_loadc);
        check($sformatf("v%0d n_loads", idx),   o.n_loads, v.n_loads);
        check($sformatf("v%0d n_write", idx),   o.n_write, v.n_write);
        check($sformatf("v%0d n_load_addr", idx), o.n_ldaddr, v.n_ldaddr);
        check($sformatf("v%0d n_mem_rd", idx),  o.n_memrd, v.n_memrd);
        check($sformatf("v%0d n_mem_wr", idx),  o.n_memwr, v.n_memwr);
        check($sformatf("v%0d readnum_a", idx), o.rn_a,    v.rn_a);
        check($sformatf("v%0d readnum_b", idx), o.rn_b,    v.rn_b);
        check($sformatf("v%0d writenum", idx),  o.wnum,    v.wnum);
        check($sformatf("v%0d vsel", idx),      o.vsel_w,  v.vsel_w);
        check($sformatf("v%0d ALUop", idx),     o.alu_c,   v.alu_c);
        check($sformatf("v%0d shift", idx),     o.shift_c, v.shift_c);
        check($sformatf("v%0d asel", idx),      o.asel_c,  v.asel_c);
        check($sformatf("v%0d bsel", idx),      o.bsel_c,  v.bsel_c);
        check($sformatf("v%0d sximm5", idx),    32'(o_sximm5), v.x5);
        check($sformatf("v%0d sximm8", idx),    32'(o_sximm8), v.x8);
        check($sformatf("v%0d n_err", idx),     o.n_err,   v.n_err);
        tsel = 1'b0;
    endtask

    initial begin
        bit any_seen, w_seen, reached;

        //            ts instr   dl lat  la lb lc ls wr ld rd wr  rnA rnB wn vs  alu sh as bs  x5       x8      err
        vecs.push_back('{0, 'hD0FB, 0, 2,  0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 2,  0, 0, 0, 0,  'hFFFB, 'hFFFB, 0}); // MOV R0,#-5
        vecs.push_back('{0, 'hA148, 0, 5,  1, 1, 1, 0, 1, 0, 0, 0,  1, 0, 2, 0,  0, 1, 0, 0,  'h0008, 'h0048, 0}); // ADD
        vecs.push_back('{0, 'hA908, 0, 4,  1, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 0,  'h0008, 'h0008, 0}); // CMP
        vecs.push_back('{0, 'hC0D3, 0, 4,  0, 1, 1, 0, 1, 0, 0, 0,  0, 3, 6, 0,  0, 2, 1, 0,  'hFFF3, 'hFFD3, 0}); // MOV reg
        vecs.push_back('{0, 'hB825, 0, 4,  0, 1, 1, 0, 1, 0, 0, 0,  0, 5, 1, 0,  3, 0, 0, 0,  'h0005, 'h0025, 0}); // MVN
        vecs.push_back('{0, 'hB2EF, 0, 5,  1, 1, 1, 0, 1, 0, 0, 0,  2, 7, 7, 0,  2, 1, 0, 0,  'h000F, 'hFFEF, 0}); // AND
        vecs.push_back('{0, 'h6162, 3, 8,  1, 0, 1, 0, 1, 1, 4, 0,  1, 0, 3, 3,  0, 0, 0, 1,  'h0002, 'h0062, 0}); // LDR late 3
        vecs.push_back('{0, 'h6162, 0, 5,  1, 0, 1, 0, 1, 1, 1, 0,  1, 0, 3, 3,  0, 0, 0, 1,  'h0002, 'h0062, 0}); // LDR at once
        vecs.push_back('{0, 'h8172, 2, 9,  1, 1, 2, 0, 0, 1, 0, 3,  1, 3, 0, 0,  0, 0, 1, 0,  'hFFF2, 'h0072, 0}); // STR late 2
`ifndef DP_CTRL_ILLEGAL_TRAP_EN
        vecs.push_back('{0, 'h0000, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  'h0000, 'h0000, 0}); // illegal
        vecs.push_back('{0, 'hC800, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  'h0000, 'h0000, 0}); // illegal
`endif
        vecs.push_back('{1, 'h6162, 99, 8, 1, 0, 1, 0, 0, 1, 4, 0,  1, 0, 0, 0,  0, 0, 0, 1,  'h0002, 'h0062, 0}); // timeout
        vecs.push_back('{1, 'h6162, 3, 8,  1, 0, 1, 0, 1, 1, 4, 0,  1, 0, 3, 3,  0, 0, 0, 1,  'h0002, 'h0062, 0}); // ready at limit

        reset     = 1'b1;
        s_m       = 1'b0;
        s_t       = 1'b0;
        mem_ready = 1'b0;
        in_r      = 16'h0000;
        tsel      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset w",       32'(m_w),      32'd1);
        check("reset strobes", 32'(m_any),    32'd0);
        check("reset err",     32'(m_err),    32'd0);
        check("reset sximm8",  32'(m_sximm8), 32'd0);
        check("reset w (timeout dut)", 32'(t_w), 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // HALT absorbs until reset, with no strobes and w low.
        @(negedge clk);
        in_r = 16'hE000;
        s_m  = 1'b1;
        @(posedge clk);
        #1 s_m = 1'b0;
        any_seen = 1'b0;
        w_seen   = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_seen |= m_any;
            w_seen   |= m_w;
        end
        check("halt w stays 0",   32'(w_seen),   32'd0);
        check("halt no strobes",  32'(any_seen), 32'd0);
        check("halt err",         32'(m_err),    32'd0);
        #2 reset = 1'b1;
        #1 check("halt async reset w", 32'(m_w), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after halt w", 32'(m_w), 32'd1);

        // Reset in the middle of a store handshake.
        in_r = 16'h8162;
        s_m  = 1'b1;
        @(posedge clk);
        #1 s_m = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (m_mem_cmd == 2'b10) reached = 1'b1;
        end
        check("str reaches MEM_WR", 32'(reached), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("str reset mem_cmd", 32'(m_mem_cmd), 32'd0);
        check("str reset w",       32'(m_w),       32'd1);
        @(negedge clk);
        reset = 1'b0;
        any_seen = 1'b0;
        w_seen   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            any_seen |= m_any;
            w_seen   &= m_w;
        end
        check("str post-reset strobes", 32'(any_seen), 32'd0);
        check("str post-reset w",       32'(w_seen),   32'd1);

`ifdef DP_CTRL_ILLEGAL_TRAP_EN
        // Illegal opcode traps until reset.
        @(negedge clk);
        in_r = 16'h0000;
        s_m  = 1'b1;
        @(posedge clk);
        #1 s_m = 1'b0;
        repeat (5) @(negedge clk);
        check("trap err",     32'(m_err), 32'd1);
        check("trap w",       32'(m_w),   32'd0);
        check("trap strobes", 32'(m_any), 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("trap cleared err", 32'(m_err), 32'd0);
        check("trap cleared w",   32'(m_w),   32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
